// File: rtl/instr_encoder_loader.sv
// ============================================================================
// instr_encoder_loader
// ----------------------------------------------------------------------------
// Write side of instruction fetch/decode. Takes an operation code (the same
// 5-bit code space the instruction decoder produces) plus operand fields.
// Encodes the 32-bit MIPS word and writes it into instruction memory, one word
// after another, starting at BASE_ADDR. The write pointer wraps from END_ADDR
// back to BASE_ADDR. Any legal word written here decodes back to the op_code
// that produced it.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_valid     request carries a valid op + operand fields
//   in_ready     block can accept (only in IDLE); transfer on in_valid&&in_ready
//   op_code      1..10 R-type, 11 j, 12 jal, 13..20 I-type
//   rs,rt,rd     register fields
//   shamt        shift amount (R-type)
//   imm          16-bit immediate (I-type)
//   target       26-bit jump target (j/jal)
//   flush        rewind pointer to BASE_ADDR, clear count/wrapped (IDLE only)
//   mem_we       one-cycle memory write strobe
//   mem_addr     write address (current write pointer)
//   mem_wdata    encoded instruction; holds the last encoded word when idle
//   err          one-cycle pulse when an illegal op_code is rejected
//   wrapped      sticky: the pointer has wrapped at least once
//   count        words written since reset/flush, saturating
// ============================================================================
module instr_encoder_loader #(
    parameter int                ADDR_W    = 5,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 5'd12,
    parameter logic [ADDR_W-1:0] END_ADDR  = 5'd18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_code,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              flush,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              err,
    output logic              wrapped,
    output logic [ADDR_W-1:0] count
);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENCODE = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;

    localparam logic [ADDR_W-1:0] COUNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Op-code tables. These mirror the decoder's code table, so the two blocks
    // always agree on what each code means.
    // ------------------------------------------------------------------------
    // R-type function field. Codes 1..10 only; other codes give 0.
    function automatic logic [5:0] r_funct(input logic [4:0] op);
        logic [5:0] f;
        f = 6'b000000;
        case (op)
            5'd1:    f = 6'b100000; // add
            5'd2:    f = 6'b100001; // addu
            5'd3:    f = 6'b100100; // and
            5'd4:    f = 6'b011010; // div
            5'd5:    f = 6'b011000; // mult
            5'd6:    f = 6'b100101; // or
            5'd7:    f = 6'b100111; // nor
            5'd8:    f = 6'b000000; // sll
            5'd9:    f = 6'b100010; // sub
            5'd10:   f = 6'b100110; // xor
            default: f = 6'b000000;
        endcase
        return f;
    endfunction

    // Major opcode for J- and I-type codes. R-type codes use the all-zero
    // SPECIAL opcode, which is also the default here.
    function automatic logic [5:0] major_opc(input logic [4:0] op);
        logic [5:0] o;
        o = 6'b000000;
        case (op)
            5'd11:   o = 6'b000010; // j
            5'd12:   o = 6'b000011; // jal
            5'd13:   o = 6'b001000; // addi
            5'd14:   o = 6'b001001; // addiu
            5'd15:   o = 6'b001100; // andi
            5'd16:   o = 6'b001101; // ori
            5'd17:   o = 6'b000100; // beq
            5'd18:   o = 6'b000101; // bne
            5'd19:   o = 6'b100011; // lw
            5'd20:   o = 6'b101011; // sw
            default: o = 6'b000000;
        endcase
        return o;
    endfunction

    function automatic logic is_rtype(input logic [4:0] op);
        return (op >= 5'd1) && (op <= 5'd10);
    endfunction

    function automatic logic is_jtype(input logic [4:0] op);
        return (op == 5'd11) || (op == 5'd12);
    endfunction

    function automatic logic is_itype(input logic [4:0] op);
        return (op >= 5'd13) && (op <= 5'd20);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]        state;

    // Request captured at accept, so the caller may change its inputs at once
    logic [4:0]        req_op;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [4:0]        req_shamt;
    logic [15:0]       req_imm;
    logic [25:0]       req_target;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] count_q;
    logic              wrapped_q;
    logic              mem_we_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic              accept;
    logic              enc_legal;
    logic [31:0]       enc_word;
    logic              at_end;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign at_end   = (ptr == END_ADDR);

    // ------------------------------------------------------------------------
    // Encoder. It works on the captured request, so the word is ready to be
    // registered during the ENCODE state. Fields that the format does not use
    // are dropped.
    // ------------------------------------------------------------------------
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b0;
        if (is_rtype(req_op)) begin
            enc_legal = 1'b1;
            enc_word  = {6'b000000, req_rs, req_rt, req_rd, req_shamt,
                         r_funct(req_op)};
        end else if (is_jtype(req_op)) begin
            enc_legal = 1'b1;
            enc_word  = {major_opc(req_op), req_target};
        end else if (is_itype(req_op)) begin
            enc_legal = 1'b1;
            enc_word  = {major_opc(req_op), req_rs, req_rt, req_imm};
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM: IDLE -> ENCODE -> (WRITE | IDLE on illegal) -> IDLE
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state <= ST_ENCODE;
                ST_ENCODE: state <= enc_legal ? ST_WRITE : ST_IDLE;
                ST_WRITE:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_op     <= 5'd0;
            req_rs     <= 5'd0;
            req_rt     <= 5'd0;
            req_rd     <= 5'd0;
            req_shamt  <= 5'd0;
            req_imm    <= 16'h0000;
            req_target <= 26'h0;
        end else if (accept) begin
            req_op     <= op_code;
            req_rs     <= rs;
            req_rt     <= rt;
            req_rd     <= rd;
            req_shamt  <= shamt;
            req_imm    <= imm;
            req_target <= target;
        end
    end

    // ------------------------------------------------------------------------
    // Write pointer, word count and wrap flag.
    // Flush is only seen in IDLE. The pointer moves only in WRITE, so a flush
    // that arrives with an accepted request already applies before that
    // request's word gets an address.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= BASE_ADDR;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && flush) begin
                ptr       <= BASE_ADDR;
                count_q   <= '0;
                wrapped_q <= 1'b0;
            end else if (state == ST_WRITE) begin
                if (at_end) begin
                    ptr       <= BASE_ADDR;
                    wrapped_q <= 1'b1;
                end else begin
                    ptr <= ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                if (count_q != COUNT_MAX)
                    count_q <= count_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory-side outputs and error pulse.
    // mem_we and err are set in ENCODE, so each lasts exactly one cycle.
    // mem_wdata changes only on a legal encode. A rejected op therefore leaves
    // the previous word visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            if (state == ST_ENCODE) begin
                if (enc_legal) begin
                    mem_we_q <= 1'b1;
                    wdata_q  <= enc_word;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = ptr;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign wrapped   = wrapped_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader. It drives inputs on the falling
// edge and samples outputs on the falling edge. Each expected word below is
// encoded by hand. The round-trip pass decodes each word with a small decoder
// in the bench.
// ============================================================================
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op_code = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        flush = 1'b0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic        wrapped;
    logic [4:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target), .flush(flush), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err),
        .wrapped(wrapped), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decoder model: turns a MIPS word back into the decoder's op code
    function automatic logic [4:0] decode(input logic [31:0] w);
        logic [4:0] c;
        c = 5'd0;
        if (w[31:26] == 6'b000000) begin
            case (w[5:0])
                6'b100000: c = 5'd1;  6'b100001: c = 5'd2;
                6'b100100: c = 5'd3;  6'b011010: c = 5'd4;
                6'b011000: c = 5'd5;  6'b100101: c = 5'd6;
                6'b100111: c = 5'd7;  6'b000000: c = 5'd8;
                6'b100010: c = 5'd9;  6'b100110: c = 5'd10;
                default:   c = 5'd0;
            endcase
        end else begin
            case (w[31:26])
                6'b000010: c = 5'd11; 6'b000011: c = 5'd12;
                6'b001000: c = 5'd13; 6'b001001: c = 5'd14;
                6'b001100: c = 5'd15; 6'b001101: c = 5'd16;
                6'b000100: c = 5'd17; 6'b000101: c = 5'd18;
                6'b100011: c = 5'd19; 6'b101011: c = 5'd20;
                default:   c = 5'd0;
            endcase
        end
        return c;
    endfunction

    // Call on a falling edge. Returns 1 ns after the accept edge.
    task automatic launch(input logic [4:0] op, input logic [4:0] a_rs, a_rt, a_rd,
                          a_sh, input logic [15:0] a_imm, input logic [25:0] a_tgt,
                          input logic do_flush);
        chk("ready_before", in_ready, 1'b1);
        op_code = op; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh;
        imm = a_imm; target = a_tgt; flush = do_flush; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        op_code = 5'd31; rs = '1; rt = '1; rd = '1; shamt = '1; imm = '1; target = '1;
    endtask

    // Full write transaction. Ends on the falling edge after the pointer update.
    task automatic do_write(input logic [4:0] op, input logic [4:0] a_rs, a_rt, a_rd,
                            a_sh, input logic [15:0] a_imm, input logic [25:0] a_tgt,
                            input logic [4:0] exp_addr, input logic [31:0] exp_data,
                            input bit chk_data, output logic [31:0] got);
        launch(op, a_rs, a_rt, a_rd, a_sh, a_imm, a_tgt, 1'b0);
        @(negedge clk);
        chk("we_encode", mem_we, 1'b0);
        chk("busy_encode", in_ready, 1'b0);
        @(negedge clk);
        chk("we_write", mem_we, 1'b1);
        chk("addr_write", mem_addr, exp_addr);
        if (chk_data) chk("data_write", mem_wdata, exp_data);
        got = mem_wdata;
        @(negedge clk);
        chk("we_after", mem_we, 1'b0);
    endtask

    task automatic do_illegal(input logic [4:0] op);
        launch(op, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6, 1'b0);
        @(negedge clk);
        chk("err_early", err, 1'b0);
        @(negedge clk);
        chk("err_pulse", err, 1'b1);
        chk("err_no_we", mem_we, 1'b0);
        @(negedge clk);
        chk("err_clear", err, 1'b0);
        chk("err_no_we2", mem_we, 1'b0);
        chk("err_ready", in_ready, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 5'd12);
        chk("rst_data", mem_wdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_wrapped", wrapped, 1'b0);
        chk("rst_count", count, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] w;
    logic [4:0]  a;

    initial begin
        @(negedge clk);
        // Basic add
        do_reset();
        do_write(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 5'd12, 32'h00021820, 1, w);
        chk("add_count", count, 5'd1);

        // j then lw
        do_reset();
        do_write(5'd11, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'hF, 5'd12, 32'h0800000F, 1, w);
        do_write(5'd19, 5'd1, 5'd4, 5'd0, 5'd0, 16'h2, 26'h0, 5'd13, 32'h8C240002, 1, w);
        chk("jlw_count", count, 5'd2);
        chk("jlw_ptr", mem_addr, 5'd14);

        // Illegal codes: no write, and the previous word stays on mem_wdata
        do_illegal(5'd0);
        do_illegal(5'd21);
        chk("ill_ptr", mem_addr, 5'd14);
        chk("ill_count", count, 5'd2);
        chk("ill_hold", mem_wdata, 32'h8C240002);
        do_reset();
        do_illegal(5'd0);
        do_illegal(5'd31);
        chk("ill_ptr0", mem_addr, 5'd12);
        chk("ill_count0", count, 5'd0);

        // Eight back-to-back writes: the pointer wraps after address 18
        do_reset();
        do_write(5'd1,  5'd0,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0, 5'd12, 32'h00021820, 1, w);
        do_write(5'd11, 5'd0,  5'd0,  5'd0, 5'd0, 16'h0,    26'hF, 5'd13, 32'h0800000F, 1, w);
        do_write(5'd19, 5'd1,  5'd4,  5'd0, 5'd0, 16'h2,    26'h0, 5'd14, 32'h8C240002, 1, w);
        do_write(5'd8,  5'd0,  5'd2,  5'd3, 5'd4, 16'h0,    26'h0, 5'd15, 32'h00021900, 1, w);
        do_write(5'd17, 5'd1,  5'd2,  5'd0, 5'd0, 16'hFFFF, 26'h0, 5'd16, 32'h1022FFFF, 1, w);
        do_write(5'd20, 5'd29, 5'd31, 5'd0, 5'd0, 16'h8,    26'h0, 5'd17, 32'hAFBF0008, 1, w);
        chk("wrap_before", wrapped, 1'b0);
        do_write(5'd7,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0, 5'd18, 32'h00221827, 1, w);
        chk("wrap_after7", wrapped, 1'b1);
        chk("wrap_ptr", mem_addr, 5'd12);
        do_write(5'd1,  5'd0,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0, 5'd12, 32'h00021820, 1, w);
        chk("wrap_count", count, 5'd8);
        chk("wrap_sticky", wrapped, 1'b1);

        // A flush in IDLE clears the wrap flag and the count
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_wrapped", wrapped, 1'b0);
        chk("flush_count", count, 5'd0);
        chk("flush_ptr", mem_addr, 5'd12);

        // Reset while the write strobe is high
        do_reset();
        launch(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_we_hi", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we", mem_we, 1'b0);
        chk("midrst_addr", mem_addr, 5'd12);
        chk("midrst_data", mem_wdata, 32'h0);
        chk("midrst_count", count, 5'd0);
        chk("midrst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        do_write(5'd9, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 5'd12, 32'h00221822, 1, w);
        chk("midrst_count1", count, 5'd1);

        // Flush and a request on the same edge, after three writes
        do_reset();
        do_write(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 5'd12, 32'h00021820, 1, w);
        do_write(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 5'd13, 32'h00021820, 1, w);
        do_write(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 5'd14, 32'h00021820, 1, w);
        launch(5'd16, 5'd3, 5'd5, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1);
        @(negedge clk);
        chk("fv_count0", count, 5'd0);
        chk("fv_ptr0", mem_addr, 5'd12);
        @(negedge clk);
        chk("fv_we", mem_we, 1'b1);
        chk("fv_addr", mem_addr, 5'd12);
        chk("fv_data", mem_wdata, 32'h346500FF);
        @(negedge clk);
        chk("fv_count1", count, 5'd1);
        chk("fv_wrapped", wrapped, 1'b0);

        // A flush is ignored while busy
        launch(5'd1, 5'd0, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("fbusy_addr", mem_addr, 5'd13);
        flush = 1'b0;
        @(negedge clk);
        chk("fbusy_count", count, 5'd2);
        chk("fbusy_ptr", mem_addr, 5'd14);

        // Round trip for every legal code, run twice so count saturates
        do_reset();
        a = 5'd12;
        for (int pass = 0; pass < 2; pass++) begin
            for (int op = 1; op <= 20; op++) begin
                do_write(op[4:0], 5'd5, 5'd6, 5'd7, 5'd3, 16'h1234, 26'h123456, a, 32'h0, 0, w);
                chk("roundtrip", {27'd0, decode(w)}, op);
                a = (a == 5'd18) ? 5'd12 : a + 5'd1;
            end
            if (pass == 0) chk("rt_count20", count, 5'd20);
        end
        chk("rt_count_sat", count, 5'd31);
        chk("rt_ptr", mem_addr, a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
